pong_match_ctrl: RTL and testbench

Game-flow controller for the pong datapath. It sequences serve, rally, point-freeze and game-over phases, and owns the ball direction and serve side. It keeps both players' scores and tells the ball datapath when to advance and when to reload the serve position. It sits between the player buttons, the paddle/ball collision detectors and the ball position register. Its frame timing is derived from the VGA vsync output.

---
 rtl/pong_match_ctrl.sv | 169 ++++++++++++++++
 tb/tb_pong_match_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_match_ctrl.sv
// Game-flow controller for pong: serve/rally/point-freeze/game-over sequencing,
// ball direction, serve side and both players' scores, paced by vsync frame ticks.
module pong_match_ctrl #(
  parameter int unsigned SCORE_MAX     = 7,
  parameter int unsigned FREEZE_FRAMES = 60,
  parameter logic [9:0]  LEFT_LIMIT    = 10'd8,
  parameter logic [9:0]  RIGHT_LIMIT   = 10'd632
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vsync,
  input  logic       p1_srv,
  input  logic       p2_srv,
  input  logic       p1_hit,
  input  logic       p2_hit,
  input  logic [9:0] ball_x,
  output logic       frame_tick,
  output logic       ball_run,
  output logic       ball_dir,
  output logic       ball_load,
  output logic [1:0] serve_side,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic       game_over
);

  typedef enum logic [1:0] {SERVE, PLAY, POINT, OVER} state_e;

  localparam logic [3:0] SCORE_MAX_C = 4'(SCORE_MAX);
  localparam logic [7:0] FREEZE_C    = 8'(FREEZE_FRAMES);

  state_e      state_q, state_d;
  logic        vsync_q;
  logic        p1_srv_q, p2_srv_q;
  logic        frame_tick_q;
  logic        ball_run_q;
  logic        ball_dir_q, ball_dir_d;
  logic        ball_load_q, ball_load_d;
  logic [1:0]  serve_side_q, serve_side_d;
  logic [3:0]  p1_score_q, p1_score_d;
  logic [3:0]  p2_score_q, p2_score_d;
  logic        game_over_q;
  logic [7:0]  freeze_cnt_q, freeze_cnt_d;

  logic        p1_rise, p2_rise;

  // Edge detection: a button already held when the state changes is not a press.
  assign p1_rise = p1_srv & ~p1_srv_q;
  assign p2_rise = p2_srv & ~p2_srv_q;

  always_comb begin
    state_d      = state_q;
    ball_dir_d   = ball_dir_q;
    ball_load_d  = 1'b0;
    serve_side_d = serve_side_q;
    p1_score_d   = p1_score_q;
    p2_score_d   = p2_score_q;
    freeze_cnt_d = freeze_cnt_q;

    case (state_q)
      SERVE: begin
        if (serve_side_q[1] && p1_rise) begin
          state_d      = PLAY;
          ball_dir_d   = 1'b0;
          serve_side_d = 2'b00;
        end else if (serve_side_q[0] && p2_rise) begin
          state_d      = PLAY;
          ball_dir_d   = 1'b1;
          serve_side_d = 2'b00;
        end
      end

      PLAY: begin
        // A paddle hit outranks a limit crossing in the same cycle.
        if (p1_hit) begin
          ball_dir_d = 1'b0;
        end else if (p2_hit) begin
          ball_dir_d = 1'b1;
        end else if (ball_x <= LEFT_LIMIT) begin
          p2_score_d   = p2_score_q + 4'd1;
          serve_side_d = 2'b10;
          if (p2_score_d == SCORE_MAX_C) begin
            state_d = OVER;
          end else begin
            state_d      = POINT;
            freeze_cnt_d = FREEZE_C;
          end
        end else if (ball_x >= RIGHT_LIMIT) begin
          p1_score_d   = p1_score_q + 4'd1;
          serve_side_d = 2'b01;
          if (p1_score_d == SCORE_MAX_C) begin
            state_d = OVER;
          end else begin
            state_d      = POINT;
            freeze_cnt_d = FREEZE_C;
          end
        end
      end

      POINT: begin
        if (frame_tick_q) begin
          if (freeze_cnt_q == 8'd1) begin
            state_d      = SERVE;
            ball_load_d  = 1'b1;
            ball_dir_d   = ~serve_side_q[1];
            freeze_cnt_d = 8'd0;
          end else begin
            freeze_cnt_d = freeze_cnt_q - 8'd1;
          end
        end
      end

      OVER: begin
        if (p1_rise || p2_rise) begin
          state_d      = SERVE;
          p1_score_d   = 4'd0;
          p2_score_d   = 4'd0;
          serve_side_d = 2'b01;
          ball_dir_d   = 1'b1;
          ball_load_d  = 1'b1;
        end
      end

      default: state_d = SERVE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= SERVE;
      vsync_q      <= 1'b0;
      p1_srv_q     <= 1'b0;
      p2_srv_q     <= 1'b0;
      frame_tick_q <= 1'b0;
      ball_run_q   <= 1'b0;
      ball_dir_q   <= 1'b1;
      ball_load_q  <= 1'b0;
      serve_side_q <= 2'b01;
      p1_score_q   <= 4'd0;
      p2_score_q   <= 4'd0;
      game_over_q  <= 1'b0;
      freeze_cnt_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      vsync_q      <= vsync;
      p1_srv_q     <= p1_srv;
      p2_srv_q     <= p2_srv;
      frame_tick_q <= vsync_q & ~vsync;
      ball_run_q   <= (state_d == PLAY);
      ball_dir_q   <= ball_dir_d;
      ball_load_q  <= ball_load_d;
      serve_side_q <= serve_side_d;
      p1_score_q   <= p1_score_d;
      p2_score_q   <= p2_score_d;
      game_over_q  <= (state_d == OVER);
      freeze_cnt_q <= freeze_cnt_d;
    end
  end

  assign frame_tick = frame_tick_q;
  assign ball_run   = ball_run_q;
  assign ball_dir   = ball_dir_q;
  assign ball_load  = ball_load_q;
  assign serve_side = serve_side_q;
  assign p1_score   = p1_score_q;
  assign p2_score   = p2_score_q;
  assign game_over  = game_over_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed scenarios followed by randomized play, checked against a rule-level
// reference model of the match controller.
module tb_pong_match_ctrl;

  localparam int SM = 3;
  localparam int FF = 2;

  localparam int PH_SERVE = 0;
  localparam int PH_PLAY  = 1;
  localparam int PH_POINT = 2;
  localparam int PH_OVER  = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       vsync, p1_srv, p2_srv, p1_hit, p2_hit;
  logic [9:0] ball_x;
  logic       frame_tick, ball_run, ball_dir, ball_load, game_over;
  logic [1:0] serve_side;
  logic [3:0] p1_score, p2_score;

  int compared = 0;
  int failed   = 0;
  int cyc      = 0;

  // reference model state
  int   m_ph, m_frz, m_s1, m_s2, m_side;
  bit   m_vq, m_p1q, m_p2q, m_ft, m_run, m_dir, m_load, m_over;

  pong_match_ctrl #(
    .SCORE_MAX(SM), .FREEZE_FRAMES(FF),
    .LEFT_LIMIT(10'd8), .RIGHT_LIMIT(10'd632)
  ) dut (
    .clk(clk), .rst_n(rst_n), .vsync(vsync),
    .p1_srv(p1_srv), .p2_srv(p2_srv), .p1_hit(p1_hit), .p2_hit(p2_hit),
    .ball_x(ball_x), .frame_tick(frame_tick), .ball_run(ball_run),
    .ball_dir(ball_dir), .ball_load(ball_load), .serve_side(serve_side),
    .p1_score(p1_score), .p2_score(p2_score), .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ph = PH_SERVE; m_frz = 0; m_s1 = 0; m_s2 = 0; m_side = 1;
    m_vq = 0; m_p1q = 0; m_p2q = 0; m_ft = 0; m_run = 0; m_dir = 1;
    m_load = 0; m_over = 0;
  endtask

  task automatic model_step();
    bit r1, r2, tick;
    if (!rst_n) begin
      model_reset();
      return;
    end
    r1 = p1_srv && !m_p1q;
    r2 = p2_srv && !m_p2q;
    tick = m_ft;
    m_load = 0;
    case (m_ph)
      PH_SERVE: begin
        if (m_side == 2 && r1) begin m_ph = PH_PLAY; m_dir = 0; m_side = 0; end
        else if (m_side == 1 && r2) begin m_ph = PH_PLAY; m_dir = 1; m_side = 0; end
      end
      PH_PLAY: begin
        if (p1_hit) m_dir = 0;
        else if (p2_hit) m_dir = 1;
        else if (int'(ball_x) <= 8) begin
          m_s2++; m_side = 2;
          if (m_s2 == SM) m_ph = PH_OVER;
          else begin m_ph = PH_POINT; m_frz = FF; end
        end else if (int'(ball_x) >= 632) begin
          m_s1++; m_side = 1;
          if (m_s1 == SM) m_ph = PH_OVER;
          else begin m_ph = PH_POINT; m_frz = FF; end
        end
      end
      PH_POINT: begin
        if (tick) begin
          m_frz--;
          if (m_frz == 0) begin
            m_ph = PH_SERVE; m_load = 1;
            m_dir = (m_side == 2) ? 1'b0 : 1'b1;
          end
        end
      end
      default: begin
        if (r1 || r2) begin
          m_s1 = 0; m_s2 = 0; m_side = 1; m_dir = 1; m_load = 1; m_ph = PH_SERVE;
        end
      end
    endcase
    m_ft   = m_vq && !vsync;
    m_vq   = vsync;
    m_p1q  = p1_srv;
    m_p2q  = p2_srv;
    m_run  = (m_ph == PH_PLAY);
    m_over = (m_ph == PH_OVER);
  endtask

  task automatic check_model();
    logic [14:0] obs, exp;
    obs = {frame_tick, ball_run, ball_dir, ball_load, serve_side, p1_score, p2_score, game_over};
    exp = {m_ft, m_run, m_dir, m_load, 2'(m_side), 4'(m_s1), 4'(m_s2), m_over};
    chk("model", 32'(obs), 32'(exp));
    chk("load_while_run", 32'(ball_load & ball_run), 32'd0);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    cyc++;
    #1;
    check_model();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_run"},  32'(ball_run), 32'd0);
    chk({tag, "_dir"},  32'(ball_dir), 32'd1);
    chk({tag, "_load"}, 32'(ball_load), 32'd0);
    chk({tag, "_side"}, 32'(serve_side), 32'd1);
    chk({tag, "_s1"},   32'(p1_score), 32'd0);
    chk({tag, "_s2"},   32'(p2_score), 32'd0);
    chk({tag, "_over"}, 32'(game_over), 32'd0);
    chk({tag, "_tick"}, 32'(frame_tick), 32'd0);
  endtask

  // Toggle vsync through several frames; ball_load must pulse once, right after tick FF.
  task automatic run_freeze(input bit exp_dir);
    int ticks = 0, loads = 0, load_ticks = -1, gap = -1, last_tick = -100;
    for (int k = 0; k < 60; k++) begin
      vsync = (((k / 6) % 2) == 0);
      cycle();
      if (frame_tick) begin ticks++; last_tick = cyc; end
      if (ball_load) begin
        loads++;
        if (load_ticks < 0) begin load_ticks = ticks; gap = cyc - last_tick; end
      end
    end
    vsync = 1'b0;
    cycle();
    chk("freeze_loads", 32'(loads), 32'd1);
    chk("freeze_ticks_before_load", 32'(load_ticks), 32'(FF));
    chk("freeze_load_gap", 32'(gap), 32'd1);
    chk("freeze_dir", 32'(ball_dir), 32'(exp_dir));
    chk("freeze_run", 32'(ball_run), 32'd0);
  endtask

  initial begin
    int loads;
    rst_n = 1'b0; vsync = 1'b0; p1_srv = 1'b0; p2_srv = 1'b0;
    p1_hit = 1'b0; p2_hit = 1'b0; ball_x = 10'd320;
    model_reset();
    cycle(); cycle();
    chk_reset_vals("reset");
    rst_n = 1'b1;

    // p1 is not the serving player: ignored
    p1_srv = 1'b1; cycle(); cycle();
    chk("p1_ignored_run", 32'(ball_run), 32'd0);
    chk("p1_ignored_side", 32'(serve_side), 32'd1);
    p1_srv = 1'b0; cycle();

    p2_srv = 1'b1; cycle();
    chk("serve_run", 32'(ball_run), 32'd1);
    chk("serve_dir", 32'(ball_dir), 32'd1);
    chk("serve_side_clear", 32'(serve_side), 32'd0);
    p2_srv = 1'b0;

    ball_x = 10'd5; cycle();
    chk("miss_left_s2", 32'(p2_score), 32'd1);
    chk("miss_left_side", 32'(serve_side), 32'd2);
    chk("miss_left_run", 32'(ball_run), 32'd0);
    ball_x = 10'd320;
    run_freeze(1'b0);

    p1_srv = 1'b1; cycle();
    chk("p1_serve_run", 32'(ball_run), 32'd1);
    chk("p1_serve_dir", 32'(ball_dir), 32'd0);
    p1_srv = 1'b0;

    p1_hit = 1'b1; ball_x = 10'd5; cycle();
    chk("hit_vs_miss_dir", 32'(ball_dir), 32'd0);
    chk("hit_vs_miss_s2", 32'(p2_score), 32'd1);
    chk("hit_vs_miss_run", 32'(ball_run), 32'd1);
    p1_hit = 1'b0; ball_x = 10'd320;

    p2_hit = 1'b1; cycle();
    chk("p2_hit_dir", 32'(ball_dir), 32'd1);
    p1_hit = 1'b1; cycle();
    chk("both_hit_dir", 32'(ball_dir), 32'd0);
    p1_hit = 1'b0; p2_hit = 1'b0;

    // p1 scores up to SM on right-side misses
    for (int s = 1; s < SM; s++) begin
      ball_x = 10'd635; cycle();
      chk("miss_right_s1", 32'(p1_score), 32'(s));
      chk("miss_right_side", 32'(serve_side), 32'd1);
      ball_x = 10'd320;
      run_freeze(1'b1);
      p2_srv = 1'b1; cycle();
      chk("p2_reserve_run", 32'(ball_run), 32'd1);
      p2_srv = 1'b0;
    end
    p1_srv = 1'b1; cycle();
    ball_x = 10'd700; cycle();
    chk("over_s1", 32'(p1_score), 32'(SM));
    chk("over_flag", 32'(game_over), 32'd1);
    ball_x = 10'd320;
    cycle(); cycle(); cycle();
    chk("held_no_restart", 32'(game_over), 32'd1);
    chk("held_score", 32'(p1_score), 32'(SM));
    p1_srv = 1'b0; cycle();
    p1_srv = 1'b1; cycle();
    chk("restart_load", 32'(ball_load), 32'd1);
    chk("restart_s1", 32'(p1_score), 32'd0);
    chk("restart_s2", 32'(p2_score), 32'd0);
    chk("restart_side", 32'(serve_side), 32'd1);
    chk("restart_over", 32'(game_over), 32'd0);
    cycle();
    chk("restart_load_once", 32'(ball_load), 32'd0);
    p1_srv = 1'b0;

    // reset asynchronously in the middle of a point freeze
    p2_srv = 1'b1; cycle(); p2_srv = 1'b0;
    ball_x = 10'd3; cycle(); ball_x = 10'd320;
    vsync = 1'b1; cycle(); cycle();
    vsync = 1'b0; cycle(); cycle();
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_model();
    chk_reset_vals("async_rst");
    cycle(); cycle();
    rst_n = 1'b1;
    loads = 0;
    for (int k = 0; k < 40; k++) begin
      vsync = (((k / 5) % 2) == 0);
      cycle();
      if (ball_load) loads++;
    end
    chk("post_rst_no_load", 32'(loads), 32'd0);
    chk("post_rst_run", 32'(ball_run), 32'd0);

    // randomized play against the model
    vsync = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      int sel;
      sel = int'($urandom_range(0, 19));
      if (sel == 0) ball_x = 10'($urandom_range(0, 8));
      else if (sel == 1) ball_x = 10'($urandom_range(632, 1023));
      else ball_x = 10'($urandom_range(9, 631));
      p1_hit = ($urandom_range(0, 15) == 0);
      p2_hit = ($urandom_range(0, 15) == 0);
      p1_srv = ($urandom_range(0, 3) == 0);
      p2_srv = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) vsync = ~vsync;
      rst_n = ($urandom_range(0, 999) != 0);
      cycle();
    end
    rst_n = 1'b1;
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
